// File: rtl/dmem_responder.sv
// Data-memory responder: one word access at a time, fixed LATENCY busy cycles, then a done pulse.
// Optional out-of-range checking is enabled by defining DMEM_RESP_OOR_CHECK_EN.
module dmem_responder #(
  parameter int ADDR_WORDS_POW2 = 10,
  parameter int LATENCY         = 2
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        dmem_read_i,
  input  logic        dmem_write_i,
  input  logic [31:0] dmem_addr_i,
  input  logic [31:0] dmem_data_i,
  output logic [31:0] dmem_rd_data_o,
  output logic        dmem_done_o,
  output logic        err_o
);

  localparam int         WORDS    = 2 ** ADDR_WORDS_POW2;
  localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                     r_state;
  logic [7:0]                 r_cnt;
  logic [ADDR_WORDS_POW2-1:0] r_idx;
  logic [31:0]                r_wdata;
  logic                       r_rd;
  logic                       r_wr;
  logic [31:0]                r_rd_data;
  logic                       r_done;
  logic [31:0]                r_mem [0:WORDS-1];
  logic                       w_commit;
  logic                       w_oor;
  logic                       w_mem_we;

`ifdef DMEM_RESP_OOR_CHECK_EN
  logic r_oor;
  logic r_err;
  assign w_oor = r_oor;
  assign err_o = r_err;
`else
  assign w_oor = 1'b0;
  assign err_o = 1'b0;
`endif

  assign w_commit = (r_state == BUSY) && (r_cnt == 8'd0);
  assign w_mem_we = w_commit && r_wr && !w_oor;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state   <= IDLE;
      r_cnt     <= 8'd0;
      r_idx     <= '0;
      r_wdata   <= 32'h0;
      r_rd      <= 1'b0;
      r_wr      <= 1'b0;
      r_rd_data <= 32'h0;
      r_done    <= 1'b0;
`ifdef DMEM_RESP_OOR_CHECK_EN
      r_oor     <= 1'b0;
      r_err     <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (dmem_read_i || dmem_write_i) begin
            r_idx   <= dmem_addr_i[ADDR_WORDS_POW2+1:2];
            r_wdata <= dmem_data_i;
            r_rd    <= dmem_read_i;
            r_wr    <= dmem_write_i;
            r_cnt   <= CNT_LOAD;
`ifdef DMEM_RESP_OOR_CHECK_EN
            r_oor   <= |dmem_addr_i[31:ADDR_WORDS_POW2+2];
`endif
            r_state <= BUSY;
          end
        end
        BUSY: begin
          if (r_cnt != 8'd0) begin
            r_cnt <= r_cnt - 8'd1;
          end else begin
            // Read samples the array before the same-edge write lands (read-before-write).
            if (r_rd) begin
              r_rd_data <= w_oor ? 32'hDEAD_BEEF : r_mem[r_idx];
            end
`ifdef DMEM_RESP_OOR_CHECK_EN
            if (r_oor) begin
              r_err <= 1'b1;
            end
`endif
            r_done  <= 1'b1;
            r_state <= RESP;
          end
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Array is deliberately left out of reset so committed writes survive a reset pulse.
  always_ff @(posedge clk_i) begin
    if (w_mem_we) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

  assign dmem_rd_data_o = r_rd_data;
  assign dmem_done_o    = r_done;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder with LATENCY=2, ADDR_WORDS_POW2=10.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset_ni = 1'b0;
  logic        dmem_read_i = 1'b0;
  logic        dmem_write_i = 1'b0;
  logic [31:0] dmem_addr_i = 32'h0;
  logic [31:0] dmem_data_i = 32'h0;
  logic [31:0] dmem_rd_data_o;
  logic        dmem_done_o;
  logic        err_o;

  int n_checks = 0;
  int n_pass   = 0;

  dmem_responder #(.ADDR_WORDS_POW2(10), .LATENCY(2)) u_dut (
    .clk_i          (clk),
    .reset_ni       (reset_ni),
    .dmem_read_i    (dmem_read_i),
    .dmem_write_i   (dmem_write_i),
    .dmem_addr_i    (dmem_addr_i),
    .dmem_data_i    (dmem_data_i),
    .dmem_rd_data_o (dmem_rd_data_o),
    .dmem_done_o    (dmem_done_o),
    .err_o          (err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one access in the current cycle (cycle 0), drop it in cycle 1, observe cycles 1..6.
  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, output int dc, output int pulses,
                        output logic [31:0] rdv);
    dmem_read_i  = rd;
    dmem_write_i = wr;
    dmem_addr_i  = addr;
    dmem_data_i  = data;
    dc = -1;
    pulses = 0;
    rdv = 32'h0;
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c == 1) begin
        dmem_read_i  = 1'b0;
        dmem_write_i = 1'b0;
        dmem_addr_i  = 32'hFFFF_FFFC;
        dmem_data_i  = 32'h5555_5555;
      end
      if (dmem_done_o === 1'b1) begin
        pulses++;
        if (dc < 0) begin
          dc  = c;
          rdv = dmem_rd_data_o;
        end
      end
    end
  endtask

  int          dc;
  int          np;
  logic [31:0] rdv;
  logic [31:0] mask;

  initial begin
    // Reset state
    step();
    step();
    chk("rst_done", {31'h0, dmem_done_o}, 32'h0);
    chk("rst_rd_data", dmem_rd_data_o, 32'h0);
    chk("rst_err", {31'h0, err_o}, 32'h0);
    reset_ni = 1'b1;
    step();

    access(1'b0, 1'b1, 32'h10, 32'h1234_5678, dc, np, rdv);
    chk("wr10_done_cycle", 32'(dc), 32'd3);
    chk("wr10_pulses", 32'(np), 32'd1);

    access(1'b1, 1'b0, 32'h10, 32'h0, dc, np, rdv);
    chk("rd10_done_cycle", 32'(dc), 32'd3);
    chk("rd10_data_at_done", rdv, 32'h1234_5678);
    chk("rd10_data_held", dmem_rd_data_o, 32'h1234_5678);

    access(1'b0, 1'b1, 32'h14, 32'hFFFF_0000, dc, np, rdv);
    chk("wr14_done_cycle", 32'(dc), 32'd3);
    chk("wr14_rd_data_unchanged", dmem_rd_data_o, 32'h1234_5678);

    // Byte offset bits are ignored
    access(1'b1, 1'b0, 32'h17, 32'h0, dc, np, rdv);
    chk("rd17_word_only", rdv, 32'hFFFF_0000);

    // Request held across done: accepted again in cycle 4, done in cycle 7
    dmem_read_i = 1'b1;
    dmem_addr_i = 32'h10;
    mask = 32'h0;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (dmem_done_o === 1'b1) mask[c] = 1'b1;
      if (c == 7) dmem_read_i = 1'b0;
    end
    chk("b2b_done_mask", mask, 32'h0000_0088);
    chk("b2b_rd_data", dmem_rd_data_o, 32'h1234_5678);

    // Simultaneous read+write is read-before-write with one done
    access(1'b0, 1'b1, 32'h20, 32'h0000_000A, dc, np, rdv);
    access(1'b1, 1'b1, 32'h20, 32'h0000_000B, dc, np, rdv);
    chk("rw20_old_data", rdv, 32'h0000_000A);
    chk("rw20_pulses", 32'(np), 32'd1);
    chk("rw20_done_cycle", 32'(dc), 32'd3);
    access(1'b1, 1'b0, 32'h20, 32'h0, dc, np, rdv);
    chk("rd20_new_data", rdv, 32'h0000_000B);

    // Reset during cycle 2 of a write loses the write and its done pulse
    access(1'b0, 1'b1, 32'h30, 32'h0000_0005, dc, np, rdv);
    dmem_write_i = 1'b1;
    dmem_addr_i  = 32'h30;
    dmem_data_i  = 32'h0000_0099;
    step();
    dmem_write_i = 1'b0;
    step();
    reset_ni = 1'b0;
    #1;
    chk("midrst_done", {31'h0, dmem_done_o}, 32'h0);
    chk("midrst_rd_data", dmem_rd_data_o, 32'h0);
    #1;
    reset_ni = 1'b1;
    np = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (dmem_done_o === 1'b1) np++;
    end
    chk("midrst_no_done", 32'(np), 32'd0);
    access(1'b1, 1'b0, 32'h30, 32'h0, dc, np, rdv);
    chk("rd30_after_rst", rdv, 32'h0000_0005);

    // Upper address bits: aliasing by default, out-of-range with the check enabled
    access(1'b0, 1'b1, 32'h0, 32'hCAFE_0000, dc, np, rdv);
    access(1'b1, 1'b0, 32'h0000_1000, 32'h0, dc, np, rdv);
    chk("oor_rd_done_cycle", 32'(dc), 32'd3);
`ifdef DMEM_RESP_OOR_CHECK_EN
    chk("oor_rd_data", rdv, 32'hDEAD_BEEF);
    chk("oor_err_set", {31'h0, err_o}, 32'h1);
    access(1'b0, 1'b1, 32'h0000_1000, 32'h0000_0077, dc, np, rdv);
    access(1'b1, 1'b0, 32'h0, 32'h0, dc, np, rdv);
    chk("oor_wr_dropped", rdv, 32'hCAFE_0000);
    chk("oor_err_sticky", {31'h0, err_o}, 32'h1);
`else
    chk("alias_rd_data", rdv, 32'hCAFE_0000);
    chk("alias_err_zero", {31'h0, err_o}, 32'h0);
    access(1'b0, 1'b1, 32'h0000_1000, 32'h0000_0077, dc, np, rdv);
    access(1'b1, 1'b0, 32'h0, 32'h0, dc, np, rdv);
    chk("alias_wr_word0", rdv, 32'h0000_0077);
    chk("alias_err_still_zero", {31'h0, err_o}, 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
